// File: rtl/usb_utmi_packet_summarizer.sv
// Condenses UTMI rx/tx packets and SE0 bus resets into 64-bit timestamped
// summary records, delivered through a show-ahead valid/ready FIFO.
module usb_utmi_packet_summarizer #(
  parameter int FIFO_LOG2  = 3,
  parameter int SE0_CYCLES = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic [7:0]  utmi_rx_data,
  input  logic        utmi_rx_valid,
  input  logic        utmi_rx_active,
  input  logic [7:0]  utmi_tx_data,
  input  logic        utmi_tx_valid,
  input  logic        utmi_tx_ready,
  input  logic [1:0]  utmi_line_state,
  output logic [63:0] rec_data,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [15:0] drop_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RX_PKT = 2'b01,
    TX_PKT = 2'b10
  } state_e;

  localparam int         DEPTH          = 1 << FIFO_LOG2;
  localparam int         SE0_W          = $clog2(SE0_CYCLES + 1);
  localparam logic [1:0] TYPE_RX        = 2'b00;
  localparam logic [1:0] TYPE_TX        = 2'b01;
  localparam logic [1:0] TYPE_BUS_RESET = 2'b10;

  state_e             state_q;
  logic [31:0]        ts_q;
  logic               armed_q;
  logic [31:0]        pkt_ts_q;
  logic [11:0]        len_q;
  logic               len_sat_q;
  logic [7:0]         pid_q;
  logic [SE0_W-1:0]   se0_cnt_q;
  logic [31:0]        se0_ts_q;
  logic               se0_done_q;
  logic               ovf_q;
  logic [15:0]        drop_count_q;
  logic [FIFO_LOG2:0] wr_ptr_q;
  logic [FIFO_LOG2:0] rd_ptr_q;
  logic [63:0]        mem [DEPTH];

  logic        byte_strobe;
  logic [7:0]  byte_data;
  logic        pkt_end;
  logic        pid_err;
  logic        se0_now;
  logic        se0_ok;
  logic        se0_fire;
  logic [31:0] se0_start_ts;
  logic        push_valid;
  logic [63:0] push_rec;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_accept;
  logic        push_drop;

  assign byte_strobe = (state_q == RX_PKT) ? (utmi_rx_valid & utmi_rx_active)
                     : (state_q == TX_PKT) ? (utmi_tx_valid & utmi_tx_ready)
                     : 1'b0;
  assign byte_data   = (state_q == TX_PKT) ? utmi_tx_data : utmi_rx_data;
  assign pkt_end     = ((state_q == RX_PKT) && !utmi_rx_active) ||
                       ((state_q == TX_PKT) && !utmi_tx_valid);
  // A PID byte is valid when its high nibble is the complement of its low nibble.
  assign pid_err     = (len_q != 12'd0) && (pid_q[7:4] != ~pid_q[3:0]);

  assign se0_now      = (utmi_line_state == 2'b00);
  assign se0_ok       = (state_q == IDLE) && capture_en && !utmi_rx_active;
  assign se0_fire     = se0_ok && se0_now && !se0_done_q &&
                        (se0_cnt_q == SE0_W'(SE0_CYCLES - 1));
  assign se0_start_ts = (se0_cnt_q == '0) ? ts_q : se0_ts_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    push_valid = pkt_end | se0_fire;
    push_rec   = '0;
    if (pkt_end) begin
      push_rec = {pkt_ts_q, pid_err, len_sat_q, ovf_q, 1'b0,
                  (state_q == TX_PKT) ? TYPE_TX : TYPE_RX, 2'b00,
                  pid_q, 4'h0, len_q};
    end else if (se0_fire) begin
      push_rec = {se0_start_ts, 2'b00, ovf_q, 1'b0, TYPE_BUS_RESET, 2'b00,
                  8'h00, 4'h0, 12'h000};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      armed_q    <= 1'b0;
      pkt_ts_q   <= '0;
      len_q      <= '0;
      len_sat_q  <= 1'b0;
      pid_q      <= '0;
      se0_cnt_q  <= '0;
      se0_ts_q   <= '0;
      se0_done_q <= 1'b0;
    end else begin
      ts_q <= ts_q + 32'd1;

      // Only arm once the bus is quiet so a packet already in flight is never half-recorded.
      if (!capture_en) begin
        armed_q <= 1'b0;
      end else if (!utmi_rx_active && !utmi_tx_valid) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (capture_en && armed_q && (utmi_rx_active || utmi_tx_valid)) begin
            state_q   <= utmi_rx_active ? RX_PKT : TX_PKT;
            pkt_ts_q  <= ts_q;
            len_q     <= '0;
            len_sat_q <= 1'b0;
            pid_q     <= '0;
          end
        end
        RX_PKT, TX_PKT: begin
          if (pkt_end) begin
            state_q <= IDLE;
          end else if (byte_strobe) begin
            if (len_q == 12'd0) begin
              pid_q <= byte_data;
            end
            if (len_q == 12'hFFF) begin
              len_sat_q <= 1'b1;
            end else begin
              len_q <= len_q + 12'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (!se0_now) begin
        se0_cnt_q  <= '0;
        se0_done_q <= 1'b0;
      end else if (!se0_ok || se0_done_q) begin
        se0_cnt_q <= '0;
      end else if (se0_fire) begin
        se0_cnt_q  <= '0;
        se0_done_q <= 1'b1;
      end else begin
        if (se0_cnt_q == '0) begin
          se0_ts_q <= ts_q;
        end
        se0_cnt_q <= se0_cnt_q + 1'b1;
      end
    end
  end

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                       (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign pop         = !fifo_empty && rec_ready;
  assign push_accept = push_valid && (!fifo_full || pop);
  assign push_drop   = push_valid && !push_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (push_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_drop) begin
        ovf_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_q <= drop_count_q + 16'd1;
        end
      end else if (push_accept) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // NOTE: record storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wr_ptr_q[FIFO_LOG2-1:0]] <= push_rec;
    end
  end

  assign rec_valid  = !fifo_empty;
  assign rec_data   = fifo_empty ? 64'd0 : mem[rd_ptr_q[FIFO_LOG2-1:0]];
  assign drop_count = drop_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_usb_utmi_packet_summarizer.sv
// Scoreboard bench: directed packets push hand-computed records into a queue,
// a negedge monitor pops and compares whenever a record is handed over.
module tb_usb_utmi_packet_summarizer;

  localparam int FIFO_LOG2  = 3;
  localparam int SE0_CYCLES = 150;

  logic        clk;
  logic        rst_n;
  logic        capture_en;
  logic [7:0]  utmi_rx_data;
  logic        utmi_rx_valid;
  logic        utmi_rx_active;
  logic [7:0]  utmi_tx_data;
  logic        utmi_tx_valid;
  logic        utmi_tx_ready;
  logic [1:0]  utmi_line_state;
  logic [63:0] rec_data;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] drop_count;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] tb_ts;

  usb_utmi_packet_summarizer #(
    .FIFO_LOG2 (FIFO_LOG2),
    .SE0_CYCLES(SE0_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .capture_en     (capture_en),
    .utmi_rx_data   (utmi_rx_data),
    .utmi_rx_valid  (utmi_rx_valid),
    .utmi_rx_active (utmi_rx_active),
    .utmi_tx_data   (utmi_tx_data),
    .utmi_tx_valid  (utmi_tx_valid),
    .utmi_tx_ready  (utmi_tx_ready),
    .utmi_line_state(utmi_line_state),
    .rec_data       (rec_data),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running timestamp: the value visible during the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 32'd0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_rec(input logic [31:0] ts, input logic [3:0] flags,
                                         input logic [1:0] typ, input logic [7:0] pid,
                                         input logic [11:0] len);
    return {ts, flags, typ, 2'b00, pid, 4'h0, len};
  endfunction

  // Monitor: a record is handed over on every edge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_record: got=%h expected=none", rec_data);
      end else begin
        check("record", rec_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input bit is_tx, input int n, input logic [7:0] pid, input bit gap,
                          input int cap_at, input bit cap_val, input bit expect_rec,
                          input logic [3:0] flags, input logic [11:0] exp_len,
                          input logic [7:0] exp_pid, input bit check_lat, input bit pop_at_end);
    logic       busy_exp;
    logic [7:0] b;
    busy_exp = capture_en;
    if (expect_rec) exp_q.push_back(mk_rec(tb_ts, flags, is_tx ? 2'b01 : 2'b00, exp_pid, exp_len));
    if (is_tx) utmi_tx_valid = 1'b1;
    else       utmi_rx_active = 1'b1;
    tick();
    check("busy_start", busy, busy_exp);
    for (int i = 0; i < n; i++) begin
      if (i == cap_at) capture_en = cap_val;
      b = (i == 0) ? pid : 8'(i);
      if (is_tx) begin
        utmi_tx_data  = b;
        utmi_tx_ready = 1'b0;
        tick();
        utmi_tx_ready = 1'b1;
        tick();
        utmi_tx_ready = 1'b0;
      end else begin
        utmi_rx_data  = b;
        utmi_rx_valid = 1'b1;
        tick();
        utmi_rx_valid = 1'b0;
        if (gap && i == 0) tick();
      end
    end
    tick();
    if (is_tx) utmi_tx_valid = 1'b0;
    else       utmi_rx_active = 1'b0;
    if (pop_at_end) rec_ready = 1'b1;
    if (check_lat) check("rec_valid_before_end", rec_valid, 1'b0);
    tick();
    if (pop_at_end) rec_ready = 1'b0;
    if (check_lat) check("rec_valid_after_end", rec_valid, 1'b1);
    check("busy_end", busy, 1'b0);
  endtask

  task automatic se0_run(input int cycles, input bit expect_rec);
    if (expect_rec) exp_q.push_back(mk_rec(tb_ts, 4'h0, 2'b10, 8'h00, 12'h000));
    utmi_line_state = 2'b00;
    for (int i = 1; i <= cycles; i++) begin
      tick();
      if (i == SE0_CYCLES - 1) check("se0_before_threshold", rec_valid, 1'b0);
      if (i == SE0_CYCLES)     check("se0_at_threshold", rec_valid, 1'b1);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    rec_ready = 1'b1;
    while ((exp_q.size() != 0 || rec_valid) && k < 2000) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    capture_en      = 1'b1;
    utmi_rx_data    = 8'h00;
    utmi_rx_valid   = 1'b0;
    utmi_rx_active  = 1'b0;
    utmi_tx_data    = 8'h00;
    utmi_tx_valid   = 1'b0;
    utmi_tx_ready   = 1'b0;
    utmi_line_state = 2'b01;
    rec_ready       = 1'b1;
    #23;
    check("reset_rec_valid", rec_valid, 1'b0);
    check("reset_rec_data", rec_data, 64'd0);
    check("reset_drop_count", drop_count, 16'd0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic packets and field errors.
    send_pkt(0, 3,    8'h69, 1, -1, 0, 1, 4'b0000, 12'd3,   8'h69, 1, 0);
    send_pkt(1, 515,  8'hC3, 0, -1, 0, 1, 4'b0000, 12'd515, 8'hC3, 0, 0);
    send_pkt(0, 3,    8'h2E, 0, -1, 0, 1, 4'b1000, 12'd3,   8'h2E, 0, 0);
    send_pkt(0, 5000, 8'hE1, 0, -1, 0, 1, 4'b0100, 12'hFFF, 8'hE1, 0, 0);
    send_pkt(0, 0,    8'h69, 0, -1, 0, 1, 4'b0000, 12'd0,   8'h00, 0, 0);
    drain("drain_basic");

    // Capture enable raised mid-RX, dropped mid-TX.
    capture_en = 1'b0;
    tick();
    send_pkt(0, 3, 8'h69, 0, 1, 1, 0, 4'b0000, 12'd3, 8'h69, 0, 0);
    send_pkt(0, 2, 8'h4B, 0, -1, 0, 1, 4'b0000, 12'd2, 8'h4B, 0, 0);
    send_pkt(1, 4, 8'hD2, 0, 2, 0, 1, 4'b0000, 12'd4, 8'hD2, 0, 0);
    capture_en = 1'b1;
    tick();
    send_pkt(0, 1, 8'h5A, 0, -1, 0, 1, 4'b0000, 12'd1, 8'h5A, 0, 0);
    drain("drain_control");

    // Overflow: ten packets into an eight-deep FIFO with no consumer.
    rec_ready = 1'b0;
    for (int k = 0; k < 10; k++)
      send_pkt(0, 2, 8'h69, 0, -1, 0, (k < 8), 4'b0000, 12'd2, 8'h69, 0, 0);
    check("overflow_drop_count", drop_count, 16'd2);
    check("overflow_rec_valid", rec_valid, 1'b1);
    drain("drain_overflow");
    send_pkt(0, 2, 8'h69, 0, -1, 0, 1, 4'b0010, 12'd2, 8'h69, 0, 0);
    send_pkt(0, 2, 8'h69, 0, -1, 0, 1, 4'b0000, 12'd2, 8'h69, 0, 0);
    drain("drain_after_overflow");

    // Push into a full FIFO while the head is popped in the same cycle.
    rec_ready = 1'b0;
    for (int k = 0; k < 8; k++)
      send_pkt(0, 1, 8'hA5, 0, -1, 0, 1, 4'b0000, 12'd1, 8'hA5, 0, 0);
    send_pkt(0, 1, 8'h96, 0, -1, 0, 1, 4'b0000, 12'd1, 8'h96, 0, 1);
    check("full_push_pop_drop_count", drop_count, 16'd2);
    drain("drain_full_push_pop");

    // Bus reset detection.
    se0_run(149, 0);
    utmi_line_state = 2'b01;
    repeat (3) tick();
    check("se0_short_no_record", rec_valid, 1'b0);
    se0_run(400, 1);
    utmi_line_state = 2'b01;
    tick();
    se0_run(150, 1);
    utmi_line_state = 2'b01;
    tick();
    drain("drain_bus_reset");

    // Asynchronous reset mid-packet with a record already queued.
    rec_ready = 1'b0;
    send_pkt(0, 1, 8'h69, 0, -1, 0, 0, 4'b0000, 12'd1, 8'h69, 0, 0);
    check("pre_reset_rec_valid", rec_valid, 1'b1);
    utmi_rx_active = 1'b1;
    tick();
    utmi_rx_valid = 1'b1;
    utmi_rx_data  = 8'h69;
    tick();
    check("pre_reset_busy", busy, 1'b1);
    rst_n          = 1'b0;
    utmi_rx_active = 1'b0;
    utmi_rx_valid  = 1'b0;
    #1;
    check("mid_reset_rec_valid", rec_valid, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_drop_count", drop_count, 16'd0);
    #3;
    rst_n     = 1'b1;
    rec_ready = 1'b1;
    repeat (4) tick();
    check("post_reset_no_stale", rec_valid, 1'b0);
    send_pkt(0, 3, 8'h69, 1, -1, 0, 1, 4'b0000, 12'd3, 8'h69, 1, 0);
    drain("drain_post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_utmi_packet_summarizer.md
# usb_utmi_packet_summarizer

Watches the UTMI tap from the USB core (same signals the traffic logger taps) and condenses each USB packet, in either direction, into one 64-bit timestamped summary record: event type, PID, byte length and error flags. It also emits a record for each detected bus reset (SE0). Records leave through a small show-ahead FIFO with a valid/ready handshake. The block sits directly upstream of the traffic logger's record buffer and runs in the 60 MHz ULPI clock domain.

## Interface
Parameters:
- FIFO_LOG2, 3: record FIFO depth = 2^FIFO_LOG2 records.
- SE0_CYCLES, 150: consecutive SE0 cycles that declare a bus reset (2.5 µs at 60 MHz).

Ports:
- clk  in  1  ULPI clock (60 MHz); the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- capture_en  in  1  recording enable.
- utmi_rx_data  in  8  received byte.
- utmi_rx_valid  in  1  rx byte strobe.
- utmi_rx_active  in  1  receive packet in progress.
- utmi_tx_data  in  8  transmitted byte; not used for the count, but captured as the PID.
- utmi_tx_valid  in  1  transmit packet in progress.
- utmi_tx_ready  in  1  tx byte accepted.
- utmi_line_state  in  2  bus line state; 00 = SE0.
- rec_data  out  64  FIFO head record.
- rec_valid  out  1  FIFO non-empty.
- rec_ready  in  1  consumer pops the head record.
- drop_count  out  16  records dropped on full FIFO; saturates.
- busy  out  1  FSM is not IDLE.

Record layout:
- [63:32] timestamp.
- [31:28] flags:
  - bit 31: pid_err.
  - bit 30: len_sat.
  - bit 29: overflow_before.
  - bit 28: reserved, 0.
- [27:26] type: 00 = RX, 01 = TX, 10 = bus reset.
- [25:24], [15:12]: 0.
- [23:16] PID byte.
- [11:0] length.

## Operation
Timestamp counter:
- 32-bit free-running counter, increments every clk.
- Wraps 0xFFFFFFFF → 0.

FSM states: IDLE, RX_PKT, TX_PKT.
- IDLE → RX_PKT: capture_en=1 and utmi_rx_active=1. RX has priority when rx_active and tx_valid are both high in the same cycle.
- IDLE → TX_PKT: capture_en=1, utmi_tx_valid=1, utmi_rx_active=0.
- On entry to either packet state: latch the timestamp of that cycle; clear length and PID.
- RX_PKT byte count: each cycle with rx_valid & rx_active.
- TX_PKT byte count: each cycle with tx_valid & tx_ready.
- The first counted byte is latched as the PID.
- RX_PKT → IDLE: rx_active=0 sampled; the record is written at that same edge.
- TX_PKT → IDLE: tx_valid=0 sampled; the record is written at that same edge.
- Traffic in the other direction during a packet is ignored.
- capture_en drop mid-packet: the packet completes and is recorded.
- capture_en rise mid-packet: no record; wait until rx_active=0 and tx_valid=0 before arming.

Field rules:
- Length is a 12-bit count that saturates at 4095 and sets len_sat.
- Length includes PID and CRC bytes.
- pid_err = (length ≥ 1) and PID[7:4] ≠ ~PID[3:0].
- A zero-length packet gives PID=0 and pid_err=0.

Bus reset:
- Applies only in IDLE, with capture_en=1 and rx_active=0.
- An SE0 run counter counts cycles with line_state=00 and latches the timestamp of the first SE0 cycle.
- When the run reaches SE0_CYCLES, write exactly one type-10 record: length=0, PID=0.
- Re-arm only after line_state ≠ 00.
- Leaving IDLE clears the run counter.

FIFO:
- A write while full (not popped that cycle) drops the record, increments drop_count (saturating at 0xFFFF) and sets a sticky overflow flag.
- The next accepted record carries overflow_before=1; the flag clears on that write.
- Push and pop in the same cycle while full: the push is accepted.
- A pop occurs when rec_valid & rec_ready.
- Pop while empty: no effect.

## Timing
- Reset values: rec_valid=0, rec_data=0, drop_count=0, busy=0, timestamp=0, FIFO empty, FSM IDLE, overflow flag 0.
- rec_data is don't-care while rec_valid=0 after reset.
- Asynchronous reset mid-packet discards the partial packet and all queued records.
- Latency: end condition sampled at edge N → record written at edge N → rec_valid=1 in the cycle after edge N, if the FIFO was empty.
- Bus reset latency: rec_valid rises 1 cycle after the SE0_CYCLES-th SE0 sample.
- FIFO throughput: one push and one pop per cycle.
- rec_data updates after each pop to the next head with no bubble.
- busy=1 from the cycle after the start edge through the end edge.

## Test plan
- RX token: rx_active high for 6 cycles with bytes 0x69, 0x00, 0x10, start at timestamp T → one record: type 00, length 3, PID 0x69, pid_err 0, timestamp T, ready 1 cycle after rx_active falls.
- TX DATA0: PID 0xC3 + 512 data + 2 CRC bytes, tx_ready toggling every other cycle → type 01, length 515, PID 0xC3, flags 0.
- Errors:
  - RX first byte 0x2E → pid_err=1.
  - 5000-byte RX → length 4095, len_sat=1.
  - rx_active pulse with no rx_valid → length 0, PID 0.
- Overflow (FIFO_LOG2=3, rec_ready=0): 10 RX packets → 8 records queued, drop_count=2. Then drain and send one more → overflow_before=1; the following record has 0. Also a push on a full FIFO with simultaneous pop is accepted.
- Bus reset:
  - SE0 for 149 cycles → no record.
  - SE0 for 400 cycles → exactly one type-10 record with timestamp at SE0 start.
  - SE0 broken for 1 cycle, then 150 more cycles → a second record.
- Control:
  - capture_en raised mid-RX → that packet is not recorded, the next one is.
  - capture_en dropped mid-TX → that packet is recorded.
  - rst_n asserted mid-packet → rec_valid=0, busy=0 immediately; no stale record after release.
